// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake.
// It covers the 8 base ops plus SLTU, iterative shifts (one bit per cycle)
// and an iterative shift-add multiply. Flags: carryout, zero, overflow, illegal.
// Ports: clk, reset_n (async, active low); in_valid/in_ready, command, operandA, operandB;
//        out_valid/out_ready, result, carryout, zero, overflow, illegal.
// Optional: define ALU_SEQ_FLUSH_EN to add the flush input (aborts BUSY/DONE).
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
`ifdef ALU_SEQ_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         command,
  input  logic [WIDTH-1:0]   operandA,
  input  logic [WIDTH-1:0]   operandB,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carryout,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_XOR  = 4'b0010;
  localparam logic [3:0] C_SLT  = 4'b0011;
  localparam logic [3:0] C_AND  = 4'b0100;
  localparam logic [3:0] C_NAND = 4'b0101;
  localparam logic [3:0] C_NOR  = 4'b0110;
  localparam logic [3:0] C_OR   = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000;
  localparam logic [3:0] C_SLL  = 4'b1001;
  localparam logic [3:0] C_SRL  = 4'b1010;
  localparam logic [3:0] C_SRA  = 4'b1011;
  localparam logic [3:0] C_MUL  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;

  logic               flush_w;
  logic               accept;

`ifdef ALU_SEQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready & ~flush_w;

  assign result    = result_q;
  assign carryout  = carry_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

  // Single-cycle datapath on the live request inputs.
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic             slt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_ill;

  assign is_sub  = (command == C_SUB);
  assign b_eff   = is_sub ? ~operandB : operandB;
  assign sum     = {1'b0, operandA} + {1'b0, b_eff}
                 + {{WIDTH{1'b0}}, is_sub};
  assign add_ovf = (operandA[WIDTH-1] == b_eff[WIDTH-1])
                 & (sum[WIDTH-1] != operandA[WIDTH-1]);
  // Direct signed compare: immune to A-B overflow.
  assign slt     = $signed(operandA) < $signed(operandB);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (command)
      C_ADD, C_SUB: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = add_ovf;
      end
      C_XOR:  alu_res = operandA ^ operandB;
      C_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      C_AND:  alu_res = operandA & operandB;
      C_NAND: alu_res = ~(operandA & operandB);
      C_NOR:  alu_res = ~(operandA | operandB);
      C_OR:   alu_res = operandA | operandB;
      C_SLTU: alu_res = {{(WIDTH-1){1'b0}}, operandA < operandB};
      C_SLL, C_SRL, C_SRA, C_MUL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // Iterative step: one shift bit or one shift-add multiply bit.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign mul_sum = {1'b0, hi_q}
                 + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

  always_comb begin
    step_hi = hi_q;
    step_lo = lo_q;
    case (op_q)
      C_SLL: step_lo = {lo_q[WIDTH-2:0], 1'b0};
      C_SRL: step_lo = {1'b0, lo_q[WIDTH-1:1]};
      C_SRA: step_lo = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
      C_MUL: begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  logic is_shift_cmd;
  logic [SHAMT_W-1:0] shamt;

  assign is_shift_cmd = (command == C_SLL) | (command == C_SRL)
                      | (command == C_SRA);
  assign shamt        = operandB[SHAMT_W-1:0];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = command;
          a_d   = operandA;
          hi_d  = '0;
          lo_d  = operandA;
          cnt_d = {1'b0, shamt};
          if (is_shift_cmd && shamt == '0) begin
            state_d  = DONE;
            result_d = operandA;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            ill_d    = 1'b0;
            zero_d   = (operandA == '0);
          end else if (is_shift_cmd) begin
            state_d = BUSY;
          end else if (command == C_MUL) begin
            lo_d    = operandB;
            cnt_d   = CNT_W'(WIDTH);
            state_d = BUSY;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            carry_d  = alu_carry;
            ovf_d    = alu_ovf;
            ill_d    = alu_ill;
            zero_d   = (alu_res == '0);
          end
        end
      end
      BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - 1'b1;
        // Result is published only on the final step.
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = step_lo;
          carry_d  = 1'b0;
          ill_d    = 1'b0;
          zero_d   = (step_lo == '0);
          ovf_d    = (op_q == C_MUL) && (step_hi != '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort keeps the previously presented result and flags.
    if (flush_w && state_q != IDLE) begin
      state_d  = IDLE;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      ill_d    = ill_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq.
// Each task drives one scenario and compares against hand-computed values.
module tb_alu_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  command;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carryout;
  logic        zero;
  logic        overflow;
  logic        illegal;

  int n_chk  = 0;
  int n_pass = 0;

  alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef ALU_SEQ_FLUSH_EN
    .flush     (1'b0),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .command   (command),
    .operandA  (operandA),
    .operandB  (operandB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryout  (carryout),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op, scramble inputs after accept, wait for out_valid,
  // capture outputs, then complete the output handshake.
  task automatic run_op(
    input  logic [3:0]  cmd,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic [3:0]  f,
    output int          lat,
    output bit          rdy_seen
  );
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    command  = cmd;
    operandA = a;
    operandB = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    operandA = ~a;
    operandB = ~b;
    command  = 4'h0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = 999;
    if (in_ready) rdy_seen = 1'b1;
    r = result;
    f = {carryout, zero, overflow, illegal};
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    command   = 4'h0;
    operandA  = '0;
    operandB  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_hs got %b want 10", {in_ready, out_valid});
    else n_pass++;
    n_chk++;
    if ({result, carryout, zero, overflow, illegal} !== 36'h0)
      $display("FAIL reset_out got %h %b%b%b%b want 0 0000",
               result, carryout, zero, overflow, illegal);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_add;
    logic [31:0] r;
    logic [3:0]  f;
    int lat;
    bit rs;
    run_op(4'b0000, 32'h7FFFFFFF, 32'h7FFFFFFF, r, f, lat, rs);
    n_chk++;
    if ({r, f} !== {32'hFFFFFFFE, 4'b0010} || lat != 1)
      $display("FAIL add_ovf got %h %b L=%0d want FFFFFFFE 0010 L=1",
               r, f, lat);
    else n_pass++;
    n_chk++;
    if (out_valid !== 1'b0)
      $display("FAIL add_drop got out_valid=%b want 0", out_valid);
    else n_pass++;
    run_op(4'b0000, 32'hFFFFFFFF, 32'h00000001, r, f, lat, rs);
    n_chk++;
    if ({r, f} !== {32'h0, 4'b1100} || lat != 1)
      $display("FAIL add_carry got %h %b L=%0d want 00000000 1100 L=1",
               r, f, lat);
    else n_pass++;
  endtask

  task automatic test_logic;
    logic [31:0] r;
    logic [3:0]  f;
    int lat;
    bit rs;
    run_op(4'b0001, 32'h1, 32'h2, r, f, lat, rs);
    n_chk++;
    if ({r, f} !== {32'hFFFFFFFF, 4'b0000})
      $display("FAIL sub got %h %b want FFFFFFFF 0000", r, f);
    else n_pass++;
    run_op(4'b0011, 32'h80000000, 32'h1, r, f, lat, rs);
    n_chk++;
    if ({r, f} !== {32'h1, 4'b0000})
      $display("FAIL slt got %h %b want 00000001 0000", r, f);
    else n_pass++;
    run_op(4'b1000, 32'h80000000, 32'h1, r, f, lat, rs);
    n_chk++;
    if ({r, f} !== {32'h0, 4'b0100})
      $display("FAIL sltu got %h %b want 00000000 0100", r, f);
    else n_pass++;
    run_op(4'b0101, 32'h1, 32'h2, r, f, lat, rs);
    n_chk++;
    if ({r, f} !== {32'hFFFFFFFF, 4'b0000})
      $display("FAIL nand got %h %b want FFFFFFFF 0000", r, f);
    else n_pass++;
    run_op(4'b0110, 32'h0F0F0000, 32'h00F0F000, r, f, lat, rs);
    n_chk++;
    if (r !== 32'hF0000FFF)
      $display("FAIL nor got %h want F0000FFF", r);
    else n_pass++;
  endtask

  task automatic test_shift;
    logic [31:0] r;
    logic [3:0]  f;
    int lat;
    bit rs;
    run_op(4'b1011, 32'h80000000, 32'h4, r, f, lat, rs);
    n_chk++;
    if (r !== 32'hF8000000 || lat != 5)
      $display("FAIL sra got %h L=%0d want F8000000 L=5", r, lat);
    else n_pass++;
    n_chk++;
    if (rs !== 1'b0)
      $display("FAIL sra_busy got in_ready seen=%b want 0", rs);
    else n_pass++;
    run_op(4'b1001, 32'h1, 32'h0, r, f, lat, rs);
    n_chk++;
    if (r !== 32'h1 || lat != 1)
      $display("FAIL sll0 got %h L=%0d want 00000001 L=1", r, lat);
    else n_pass++;
    run_op(4'b1010, 32'h80000000, 32'h1F, r, f, lat, rs);
    n_chk++;
    if ({r, f} !== {32'h1, 4'b0000} || lat != 32)
      $display("FAIL srl31 got %h %b L=%0d want 00000001 0000 L=32",
               r, f, lat);
    else n_pass++;
    run_op(4'b1001, 32'h00000003, 32'hFFFFFFE3, r, f, lat, rs);
    n_chk++;
    if (r !== 32'h00000018 || lat != 4)
      $display("FAIL sll3 got %h L=%0d want 00000018 L=4", r, lat);
    else n_pass++;
  endtask

  task automatic test_mul;
    logic [31:0] r;
    logic [3:0]  f;
    int lat;
    bit rs;
    run_op(4'b1100, 32'h00010000, 32'h00010000, r, f, lat, rs);
    n_chk++;
    if ({r, f} !== {32'h0, 4'b0110} || lat != 33)
      $display("FAIL mul_ovf got %h %b L=%0d want 00000000 0110 L=33",
               r, f, lat);
    else n_pass++;
    run_op(4'b1100, 32'h3, 32'h7, r, f, lat, rs);
    n_chk++;
    if ({r, f} !== {32'h15, 4'b0000} || lat != 33)
      $display("FAIL mul_small got %h %b L=%0d want 00000015 0000 L=33",
               r, f, lat);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [31:0] r;
    logic [3:0]  f;
    int lat;
    bit rs;
    bit bad;
    @(negedge clk);
    command  = 4'b0010;
    operandA = 32'h8;
    operandB = 32'h9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    operandA = 32'h12345678;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (result !== 32'h1 || !out_valid || in_ready) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (bad || result !== 32'h1 || !out_valid || in_ready)
      $display("FAIL bp_hold got %h v=%b r=%b want 00000001 v=1 r=0",
               result, out_valid, in_ready);
    else n_pass++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL bp_release got %b want 01", {out_valid, in_ready});
    else n_pass++;
    run_op(4'b1110, 32'hDEADBEEF, 32'h1, r, f, lat, rs);
    n_chk++;
    if ({r, f} !== {32'h0, 4'b0101} || lat != 1)
      $display("FAIL reserved got %h %b L=%0d want 00000000 0101 L=1",
               r, f, lat);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    logic [3:0]  f;
    int lat;
    bit rs;
    @(negedge clk);
    command  = 4'b1100;
    operandA = 32'hFFFF;
    operandB = 32'hFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({in_ready, out_valid, result, carryout, zero, overflow, illegal}
        !== {2'b10, 32'h0, 4'b0000})
      $display("FAIL rst_mid got r=%b v=%b %h %b%b%b%b want 1 0 0 0000",
               in_ready, out_valid, result, carryout, zero, overflow,
               illegal);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    run_op(4'b0000, 32'h1, 32'h3, r, f, lat, rs);
    n_chk++;
    if ({r, f} !== {32'h4, 4'b0000} || lat != 1)
      $display("FAIL rst_after got %h %b L=%0d want 00000004 0000 L=1",
               r, f, lat);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic();
    test_shift();
    test_mul();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the team's combinational 32-bit ALU.
- Keeps the 8-op command set and the carryout/zero/overflow flags.
- Adds SLTU, iterative shifts (one bit per cycle) and an iterative shift-add multiply.
- Wraps everything in a valid/ready handshake so the CPU datapath can stall on multi-cycle ops.

Parameters:
WIDTH, 32, operand/result width in bits (>=4).
SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
command  input  4  operation select
operandA  input  WIDTH  first operand
operandB  input  WIDTH  second operand / shift amount (low SHAMT_W bits)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
carryout  output  1  carry flag
zero  output  1  result == 0
overflow  output  1  signed overflow (ADD/SUB) or product truncation (MUL)
illegal  output  1  reserved command was issued

Behaviour:
- Commands:
  - 0000 ADD, 0001 SUB, 0010 XOR, 0011 SLT (signed), 0100 AND, 0101 NAND, 0110 NOR, 0111 OR.
  - 1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA, 1100 MUL.
  - 1101-1111 reserved.
- Reset (async, reset_n low): state IDLE.
  - in_ready=1 in IDLE.
  - out_valid, result, carryout, zero, overflow and illegal all 0.
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept: edge with in_valid & in_ready. Operands and command are captured at this edge; later input changes are ignored.
- Single-cycle ops (0000-1000, reserved):
  - Result and flags are registered at the accept edge; IDLE->DONE.
  - Latency L=1: out_valid is high after the accept edge.
- Shifts:
  - Count := operandB[SHAMT_W-1:0].
  - Count 0: go to DONE directly with result=operandA (L=1).
  - Otherwise go to BUSY. Each BUSY edge shifts by one bit and decrements the count. The edge that reaches 0 goes to DONE. L = 1+shamt.
  - SRA replicates the MSB; SRL and SLL fill with 0.
- MUL (unsigned shift-add):
  - BUSY for exactly WIDTH edges, so L = 1+WIDTH. The latency does not depend on the data.
  - result = low WIDTH bits of the product.
  - overflow = 1 if the high WIDTH bits are nonzero.
  - carryout = 0.
- Flags:
  - zero = (result==0) for every op, including reserved ops (zero=1).
  - carryout (ADD/SUB): carry out of A + (B or ~B) + cin, with cin=1 for SUB. For SUB, carryout=1 means no borrow.
  - overflow (ADD/SUB): sign of both operands into the adder equal and differing from the sum's sign.
  - SLT is correct even when A-B overflows.
  - For all other non-MUL ops, carryout = overflow = 0.
- Reserved commands: result=0, illegal=1, L=1. illegal is 0 for all legal ops.
- DONE: result and flags are held stable while out_ready=0. An edge with out_ready=1 goes DONE->IDLE. out_valid drops the cycle after the handshake.
- Throughput is at most one op per 2 cycles. No accept is possible while BUSY or DONE.
- Reset mid-operation (BUSY or DONE): aborts immediately. No partial result is ever presented.
- in_valid in BUSY/DONE is ignored (in_ready=0). The requester must hold the request.

Optional Feature:
ALU_SEQ_FLUSH_EN:
- Defined: adds input port flush (1 bit).
  - flush=1 at an edge in BUSY or DONE forces IDLE and clears out_valid. The result register keeps its old value.
  - flush in IDLE has no effect and takes priority over an accept in the same cycle (nothing is accepted).
- Undefined: no flush port; behaviour as above.

Test Plan:
- ADD 7FFFFFFF + 7FFFFFFF, out_ready=1 -> result FFFFFFFE, overflow=1, carryout=0, zero=0; out_valid exactly 1 edge after accept. ADD FFFFFFFF + 00000001 -> 00000000, carryout=1, zero=1, overflow=0.
- SUB 1-2 -> FFFFFFFF, carryout=0. SLT 80000000 vs 00000001 -> 00000001. SLTU on the same operands -> 00000000. NAND 1,2 -> FFFFFFFF.
- SRA 80000000 by 4 -> F8000000 at L=5; in_ready=0 for edges 1-4. SLL 00000001 by 0 -> 00000001 at L=1. SRL 80000000 by 31 -> 00000001 at L=32.
- MUL 00010000 * 00010000 -> 00000000, overflow=1, zero=1, L=33. MUL 00000003 * 00000007 -> 00000015, overflow=0.
- Back-pressure: hold out_ready=0 for 3 cycles after XOR 8,9 -> result 00000001 held stable, in_ready=0. Pulse out_ready -> IDLE next edge. Command 1110 -> result 0, illegal=1, zero=1.
- Reset mid-op: assert reset_n=0 10 cycles into a MUL -> all outputs 0 and in_ready=1 immediately (asynchronous). After release, ADD 1+3 -> 00000004 at L=1.
